// File: rtl/switch_allocator.sv
// rtl/switch_allocator.sv - 5-port round-robin output allocator with per-output packet locking
// Optional busy watchdog enabled by defining SA_WATCHDOG_EN.
module switch_allocator #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [24:0] rqs_flat,
  input  logic [4:0]  xfer_done,
  output logic [4:0]  arb_ack,
  output logic [24:0] grant_flat,
  output logic [4:0]  port_busy,
  output logic [4:0]  timeout_err
);

  logic [4:0] ack_vec [5];
  logic [4:0] ack_next;

  for (genvar o = 0; o < 5; o++) begin : g_out
    logic [2:0] ptr;
    logic [4:0] req;
    logic [4:0] win;
    logic [2:0] win_idx;
    logic [4:0] grant;
    logic       busy;
    logic       rel;

    for (genvar i = 0; i < 5; i++) begin : g_req
      assign req[i] = rqs_flat[5*i+o];
    end

    // Walk the search order backwards so the nearest requester to ptr is written last.
    always_comb begin
      logic [3:0] s;
      win     = '0;
      win_idx = '0;
      s       = '0;
      for (int k = 4; k >= 0; k--) begin
        s = {1'b0, ptr} + 4'(k);
        if (s >= 4'd5) s = s - 4'd5;
        if (req[s[2:0]]) begin
          win     = 5'b00001 << s[2:0];
          win_idx = s[2:0];
        end
      end
    end

    assign ack_vec[o] = (!busy && (|req)) ? win : 5'b00000;

`ifdef SA_WATCHDOG_EN
    logic [15:0] cnt;
    logic        err;
    logic        wdog;

    assign wdog = busy && !xfer_done[o] && ((cnt + 16'd1) == 16'(TIMEOUT));
    assign rel  = xfer_done[o] || wdog;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
        err <= 1'b0;
      end else if (!busy) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 16'd1;
        if (wdog) err <= 1'b1;
      end
    end

    assign timeout_err[o] = err;
`else
    assign rel            = xfer_done[o];
    assign timeout_err[o] = 1'b0;
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        busy  <= 1'b0;
        grant <= '0;
        ptr   <= '0;
      end else if (busy) begin
        if (rel) begin
          busy  <= 1'b0;
          grant <= '0;
        end
      end else if (|req) begin
        busy  <= 1'b1;
        grant <= win;
        ptr   <= (win_idx == 3'd4) ? 3'd0 : win_idx + 3'd1;
      end
    end

    assign grant_flat[5*o +: 5] = grant;
    assign port_busy[o]         = busy;
  end

`ifndef SA_WATCHDOG_EN
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    ack_next = '0;
    for (int o = 0; o < 5; o++) ack_next = ack_next | ack_vec[o];
  end

  always_ff @(posedge clk) begin
    if (rst) arb_ack <= '0;
    else     arb_ack <= ack_next;
  end

endmodule

// File: tb/tb_switch_allocator.sv
// tb/tb_switch_allocator.sv - directed bench with a behavioural allocation model for switch_allocator
module tb_switch_allocator;
  localparam int TO = 4;
`ifdef SA_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [24:0] rqs_flat;
  logic [4:0]  xfer_done;
  logic [4:0]  arb_ack;
  logic [24:0] grant_flat;
  logic [4:0]  port_busy;
  logic [4:0]  timeout_err;

  int total = 0;
  int bad   = 0;

  switch_allocator #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rqs_flat(rqs_flat), .xfer_done(xfer_done),
    .arb_ack(arb_ack), .grant_flat(grant_flat), .port_busy(port_busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Model state: owner of each output (-1 = idle), next-search input, busy age.
  int         owner [5] = '{-1, -1, -1, -1, -1};
  int         rr    [5] = '{0, 0, 0, 0, 0};
  int         age   [5] = '{0, 0, 0, 0, 0};
  logic [4:0] m_ack = '0;
  logic [4:0] m_err = '0;

  task automatic chk(input string nm, input logic [24:0] act, input logic [24:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_step();
    m_ack = '0;
    if (rst) begin
      for (int o = 0; o < 5; o++) begin owner[o] = -1; rr[o] = 0; age[o] = 0; end
      m_err = '0;
      return;
    end
    for (int o = 0; o < 5; o++) begin
      if (owner[o] >= 0) begin
        if (xfer_done[o]) owner[o] = -1;
        else if (WD) begin
          age[o]++;
          if (age[o] == TO) begin owner[o] = -1; m_err[o] = 1'b1; end
        end
      end else begin
        for (int k = 0; k < 5; k++) begin
          int i;
          i = (rr[o] + k) % 5;
          if (owner[o] < 0 && rqs_flat[5*i+o]) begin
            owner[o] = i;
            rr[o]    = (i + 1) % 5;
            age[o]   = 0;
            m_ack[i] = 1'b1;
          end
        end
      end
    end
  endtask

  function automatic logic [24:0] m_grant();
    logic [24:0] g;
    g = '0;
    for (int o = 0; o < 5; o++) if (owner[o] >= 0) g[5*o + owner[o]] = 1'b1;
    return g;
  endfunction

  function automatic logic [4:0] m_busy();
    logic [4:0] b;
    for (int o = 0; o < 5; o++) b[o] = (owner[o] >= 0);
    return b;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("model_ack",   {20'b0, arb_ack},     {20'b0, m_ack});
      chk("model_grant", grant_flat,           m_grant());
      chk("model_busy",  {20'b0, port_busy},   {20'b0, m_busy()});
      chk("model_err",   {20'b0, timeout_err}, {20'b0, m_err});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rqs_flat = '0; xfer_done = '0;
    tick(); tick();
    chk("rst_ack",   {20'b0, arb_ack},     25'h0);
    chk("rst_grant", grant_flat,           25'h0);
    chk("rst_busy",  {20'b0, port_busy},   25'h0);
    chk("rst_err",   {20'b0, timeout_err}, 25'h0);

    // Single request: input2 -> XPOS
    rst = 1'b0; rqs_flat[10] = 1'b1;
    tick();
    chk("single_ack",   {20'b0, arb_ack},         {20'b0, 5'b00100});
    chk("single_grant", {20'b0, grant_flat[4:0]}, {20'b0, 5'b00100});
    chk("single_busy",  {20'b0, port_busy},       {20'b0, 5'b00001});
    rqs_flat = '0;
    tick();
    chk("single_noregrant", {20'b0, arb_ack}, 25'h0);
    xfer_done[0] = 1'b1; tick(); xfer_done = '0;
    chk("single_release", {20'b0, port_busy}, 25'h0);

    // Contention on PE: inputs 0,1,3 -> order 0,1,3,0
    rqs_flat[4] = 1'b1; rqs_flat[9] = 1'b1; rqs_flat[19] = 1'b1;
    tick();
    chk("rr0_ack",   {20'b0, arb_ack},           {20'b0, 5'b00001});
    chk("rr0_grant", {20'b0, grant_flat[24:20]}, {20'b0, 5'b00001});
    rqs_flat[4] = 1'b0;
    tick();
    xfer_done[4] = 1'b1; tick(); xfer_done = '0;
    rqs_flat[4] = 1'b1;
    chk("rr_bubble_busy", {24'b0, port_busy[4]}, 25'h0);
    chk("rr_bubble_ack",  {20'b0, arb_ack},      25'h0);
    tick();
    chk("rr1_ack",   {20'b0, arb_ack},           {20'b0, 5'b00010});
    chk("rr1_grant", {20'b0, grant_flat[24:20]}, {20'b0, 5'b00010});
    rqs_flat[9] = 1'b0;
    xfer_done[4] = 1'b1; tick(); xfer_done = '0;
    chk("rr2_bubble", {20'b0, arb_ack}, 25'h0);
    tick();
    chk("rr2_ack",   {20'b0, arb_ack},           {20'b0, 5'b01000});
    chk("rr2_grant", {20'b0, grant_flat[24:20]}, {20'b0, 5'b01000});
    rqs_flat[19] = 1'b0;
    xfer_done[4] = 1'b1; tick(); xfer_done = '0;
    tick();
    chk("rr3_ack",   {20'b0, arb_ack},           {20'b0, 5'b00001});
    chk("rr3_grant", {20'b0, grant_flat[24:20]}, {20'b0, 5'b00001});
    rqs_flat[4] = 1'b0;
    xfer_done[4] = 1'b1; tick(); xfer_done = '0;

    // Busy blocking on XNEG held by input4
    rqs_flat[21] = 1'b1;
    tick();
    chk("blk_ack",   {20'b0, arb_ack},         {20'b0, 5'b10000});
    chk("blk_grant", {20'b0, grant_flat[9:5]}, {20'b0, 5'b10000});
    rqs_flat[21] = 1'b0; rqs_flat[6] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("blk_wait", {24'b0, arb_ack[1]}, 25'h0);
    end
    xfer_done[1] = 1'b1; tick(); xfer_done = '0;
    chk("blk_bubble", {24'b0, arb_ack[1]}, 25'h0);
    tick();
    chk("blk_ack1",   {20'b0, arb_ack},         {20'b0, 5'b00010});
    chk("blk_grant1", {20'b0, grant_flat[9:5]}, {20'b0, 5'b00010});
    rqs_flat = '0;
    xfer_done[1] = 1'b1; tick(); xfer_done = '0;
    chk("blk_free", {20'b0, port_busy}, 25'h0);
    xfer_done[1] = 1'b1; tick(); xfer_done = '0;
    chk("idle_done_busy",  {20'b0, port_busy}, 25'h0);
    chk("idle_done_grant", grant_flat,         25'h0);

    // Parallel grants: input i -> output 4-i
    for (int i = 0; i < 5; i++) rqs_flat[5*i + 4 - i] = 1'b1;
    tick();
    chk("par_ack",   {20'b0, arb_ack},   {20'b0, 5'b11111});
    chk("par_busy",  {20'b0, port_busy}, {20'b0, 5'b11111});
    chk("par_grant", grant_flat,         25'h0111110);
    rqs_flat = '0;
    tick();
    chk("par_ack_once", {20'b0, arb_ack}, 25'h0);

    // Reset mid-packet, then {1,3} on YPOS goes to 1
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_grant", grant_flat,         25'h0);
    chk("midrst_busy",  {20'b0, port_busy}, 25'h0);
    rqs_flat[7] = 1'b1; rqs_flat[17] = 1'b1;
    tick();
    chk("ptr_reset_ack",   {20'b0, arb_ack},           {20'b0, 5'b00010});
    chk("ptr_reset_grant", {20'b0, grant_flat[14:10]}, {20'b0, 5'b00010});
    rqs_flat = '0;

    // YPOS held with no xfer_done
    xfer_done[2] = 1'b1; tick(); xfer_done = '0;
    tick();
    rqs_flat[2] = 1'b1;
    tick();
    chk("wd_grant", {24'b0, port_busy[2]}, 25'h1);
    rqs_flat = '0;
`ifdef SA_WATCHDOG_EN
    repeat (3) tick();
    chk("wd_still_busy", {24'b0, port_busy[2]}, 25'h1);
    tick();
    chk("wd_released", {24'b0, port_busy[2]}, 25'h0);
    chk("wd_err",      {20'b0, timeout_err},  {20'b0, 5'b00100});
    repeat (3) tick();
    chk("wd_sticky", {20'b0, timeout_err}, {20'b0, 5'b00100});
    rst = 1'b1; tick(); rst = 1'b0;
    chk("wd_err_clr", {20'b0, timeout_err}, 25'h0);
`else
    repeat (8) tick();
    chk("nowd_busy", {24'b0, port_busy[2]}, 25'h1);
    chk("nowd_err",  {20'b0, timeout_err},  25'h0);
`endif
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
